// File: rtl/seq_pkg.sv
// Shared types and defaults for the serializer and the sequence detector bench.
package seq_pkg;

   localparam int unsigned SEQ_DATA_W = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_e;

endpackage

// File: rtl/ser_hold_slot.sv
// One-entry holding register with valid/ready on the write side, pop and clear on the read side.
module ser_hold_slot
   import seq_pkg::*;
#(
   parameter int unsigned W = SEQ_DATA_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_clear,
   input  logic         i_valid,
   input  logic [W-1:0] i_data,
   output logic         o_ready,
   input  logic         i_pop,
   output logic         o_full,
   output logic [W-1:0] o_data
);

   logic         r_full;
   logic [W-1:0] r_data;

   // Pop only happens while full and push only while empty, so they never collide.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_full <= 1'b0;
         r_data <= '0;
      end else if (i_clear) begin
         r_full <= 1'b0;
      end else if (i_pop) begin
         r_full <= 1'b0;
      end else if (i_valid && !r_full) begin
         r_full <= 1'b1;
         r_data <= i_data;
      end
   end

   assign o_ready = !r_full;
   assign o_full  = r_full;
   assign o_data  = r_data;

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end: words arrive over valid/ready and leave one bit per clock,
// with a holding slot so consecutive words stream without an idle bit.
module seq_serializer
   import seq_pkg::*;
#(
   parameter int unsigned DATA_W    = SEQ_DATA_W,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              flush_i,
   input  logic              in_valid_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              in_ready_o,
   output logic              ser_o,
   output logic              ser_valid_o,
   output logic              word_done_o
);

   localparam int unsigned       CNT_W   = $clog2(DATA_W);
   localparam logic [CNT_W-1:0]  LAST    = CNT_W'(DATA_W - 1);
   localparam int unsigned       OUT_IDX = MSB_FIRST ? DATA_W - 1 : 0;

   ser_state_e        r_state;
   ser_state_e        w_state_nxt;
   logic [DATA_W-1:0] r_shift;
   logic [DATA_W-1:0] w_shift_nxt;
   logic [DATA_W-1:0] w_shifted;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_last;
   logic              w_pop;
   logic              w_hold_full;
   logic [DATA_W-1:0] w_hold_data;

   ser_hold_slot #(
      .W (DATA_W)
   ) u_hold (
      .clk     (clock),
      .rst_n   (reset_n),
      .i_clear (flush_i),
      .i_valid (in_valid_i),
      .i_data  (in_data_i),
      .o_ready (in_ready_o),
      .i_pop   (w_pop),
      .o_full  (w_hold_full),
      .o_data  (w_hold_data)
   );

   assign w_shifted = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
   assign w_last    = (r_cnt == LAST);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_shift <= w_shift_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Shift register is forced to zero whenever the FSM leaves SHIFT, so ser_o idles low.
   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_cnt_nxt   = r_cnt;
      w_pop       = 1'b0;
      if (flush_i) begin
         w_state_nxt = IDLE;
         w_shift_nxt = '0;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_hold_full) begin
                  w_pop       = 1'b1;
                  w_shift_nxt = w_hold_data;
                  w_cnt_nxt   = '0;
                  w_state_nxt = SHIFT;
               end
            end
            SHIFT: begin
               if (w_last) begin
                  w_cnt_nxt = '0;
                  if (w_hold_full) begin
                     w_pop       = 1'b1;
                     w_shift_nxt = w_hold_data;
                  end else begin
                     w_shift_nxt = '0;
                     w_state_nxt = IDLE;
                  end
               end else begin
                  w_shift_nxt = w_shifted;
                  w_cnt_nxt   = r_cnt + CNT_W'(1);
               end
            end
         endcase
      end
   end

   assign ser_o       = r_shift[OUT_IDX];
   assign ser_valid_o = (r_state == SHIFT);
   assign word_done_o = (r_state == SHIFT) && w_last && !flush_i;

endmodule

// File: tb/tb_seq_serializer.sv
// Scoreboard bench for seq_serializer: an MSB-first and an LSB-first instance share one stimulus stream.
module tb_seq_serializer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       flush;
   logic       in_valid;
   logic [7:0] in_data;
   logic       rdy0, ser0, sv0, wd0;
   logic       rdy1, ser1, sv1, wd1;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   typedef struct {
      bit b0;
      bit b1;
      bit first;
      bit last;
      int acc;
   } ent_t;

   ent_t q[$];
   ent_t e;
   int   pend = 0;
   bit   exp_v;
   bit   exp_d;
   logic [2:0] hist = 3'b000;
   int   run = 0;
   int   run_max = 0;
   int   det_hits[$];

   always #5 clk = ~clk;

   seq_serializer #(.DATA_W(8), .MSB_FIRST(1'b1)) u_msb (
      .clock(clk), .reset_n(reset_n), .flush_i(flush), .in_valid_i(in_valid),
      .in_data_i(in_data), .in_ready_o(rdy0), .ser_o(ser0), .ser_valid_o(sv0),
      .word_done_o(wd0));

   seq_serializer #(.DATA_W(8), .MSB_FIRST(1'b0)) u_lsb (
      .clock(clk), .reset_n(reset_n), .flush_i(flush), .in_valid_i(in_valid),
      .in_data_i(in_data), .in_ready_o(rdy1), .ser_o(ser1), .ser_valid_o(sv1),
      .word_done_o(wd1));

   task automatic check(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
      end
   endtask

   task automatic check_int(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", nm, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor/scoreboard: a word accepted in cycle A starts no later than A+2 and bits then run back to back.
   always @(negedge clk) begin
      if (chk_en) begin
         exp_v = 1'b0;
         if (q.size() > 0) exp_v = (q[0].acc <= cyc - 2);
         check("valid_msb", sv0, exp_v);
         check("valid_lsb", sv1, exp_v);
         if (exp_v) begin
            e = q.pop_front();
            if (e.first) pend--;
            exp_d = e.last && !flush;
            check("bit_msb", ser0, e.b0);
            check("bit_lsb", ser1, e.b1);
            check("done_msb", wd0, exp_d);
            check("done_lsb", wd1, exp_d);
         end else begin
            check("idle_bit_msb", ser0, 1'b0);
            check("idle_bit_lsb", ser1, 1'b0);
            check("idle_done_msb", wd0, 1'b0);
            check("idle_done_lsb", wd1, 1'b0);
         end
         check("ready_msb", rdy0, pend == 0);
         check("ready_lsb", rdy1, pend == 0);
         if (sv0 === 1'b1) begin
            hist = {hist[1:0], ser0};
            run++;
            if (run > run_max) run_max = run;
            if (run >= 3 && hist == 3'b101) det_hits.push_back(run);
         end else begin
            hist = 3'b000;
            run  = 0;
         end
         if (!reset_n || flush) begin
            q.delete();
            pend = 0;
         end else if (in_valid && pend == 0) begin
            for (int i = 0; i < 8; i++) begin
               e.b0    = in_data[7-i];
               e.b1    = in_data[i];
               e.first = (i == 0);
               e.last  = (i == 7);
               e.acc   = cyc;
               q.push_back(e);
            end
            pend++;
         end
      end
   end

   task automatic send(input logic [7:0] d);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (rdy0 === 1'b1 && !flush) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check_int("send_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (q.size() == 0 && sv0 === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check_int("drain_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      int vcnt;
      reset_n  = 1'b0;
      flush    = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'h5A;

      // Reset with valid held high: nothing may be accepted.
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_ready", rdy0, 1'b1);
      check("rst_valid", sv0, 1'b0);
      check("rst_ser", ser0, 1'b0);
      check("rst_done", wd0, 1'b0);
      @(posedge clk); #1;
      reset_n  = 1'b1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;

      // Single word: first bit two cycles after the handshake.
      send(8'hA5);
      @(negedge clk);
      check("a5_c1_valid", sv0, 1'b0);
      @(negedge clk);
      check("a5_c2_valid", sv0, 1'b1);
      check("a5_c2_bit", ser0, 1'b1);
      wait_idle();

      // Back-to-back words stream gaplessly.
      run_max = 0;
      send(8'hF0);
      send(8'h0F);
      wait_idle();
      check_int("b2b_run", run_max, 16);

      send(8'h01);
      wait_idle();

      // Flush on the 4th bit of FF while AA sits in the slot.
      send(8'hFF);
      send(8'hAA);
      @(posedge clk); #1;
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      check("flush_valid", sv0, 1'b0);
      check("flush_ready", rdy0, 1'b1);
      vcnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (sv0 === 1'b1) vcnt++;
      end
      check_int("flush_no_aa", vcnt, 0);
      @(posedge clk); #1;

      // Overlapping 101 in the serial stream ends on bits 3 and 5.
      det_hits.delete();
      send(8'b1010_1100);
      wait_idle();
      check_int("det_count", det_hits.size(), 2);
      if (det_hits.size() == 2) begin
         check_int("det_pos0", det_hits[0], 3);
         check_int("det_pos1", det_hits[1], 5);
      end

      // Random traffic with occasional flushes.
      for (int k = 0; k < 600; k++) begin
         in_valid = ($urandom_range(0, 9) < 7);
         in_data  = 8'($urandom);
         flush    = ($urandom_range(0, 31) == 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      flush    = 1'b0;
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
